// File: rtl/ula_pkg.sv
// Shared opcodes and FSM encoding for the ula_seq sequential ALU.
package ula_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_EQ    = 4'd4;
  localparam logic [3:0] OP_GT    = 4'd5;
  localparam logic [3:0] OP_LT    = 4'd6;
  localparam logic [3:0] OP_NE    = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_NAND  = 4'd9;
  localparam logic [3:0] OP_OR    = 4'd10;
  localparam logic [3:0] OP_NOR   = 4'd11;
  localparam logic [3:0] OP_XOR   = 4'd12;
  localparam logic [3:0] OP_XNOR  = 4'd13;
  localparam logic [3:0] OP_NOT_A = 4'd14;
  localparam logic [3:0] OP_NOT_B = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } ula_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
module ula_muldiv_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic             o_ov,
  output logic [WIDTH-1:0] o_quot,
  output logic             o_dz
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               r_busy;
  logic               r_div;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;  // multiplier (mul) or dividend/quotient shifter (div)
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_b;

  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;

  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh   = {r_rem, r_mplier[WIDTH-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_b};
  assign w_rem_nxt  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
  assign w_quot_nxt = {r_mplier[WIDTH-2:0], w_ge};

  // Outputs reflect the final step so the caller can register them on the done edge.
  // A zero divisor makes every step subtract, so the quotient naturally saturates to all ones.
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_prod_lo = w_prod_nxt[WIDTH-1:0];
  assign o_ov      = |w_prod_nxt[2*WIDTH-1:WIDTH];
  assign o_quot    = w_quot_nxt;
  assign o_dz      = r_div && (r_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_div    <= 1'b0;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_b      <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_div    <= i_div;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_div ? i_a : i_b;
      r_rem    <= '0;
      r_b      <= i_b;
    end else if (r_busy) begin
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
      if (r_div) begin
        r_rem    <= w_rem_nxt;
        r_mplier <= w_quot_nxt;
      end else begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequential 16-op ALU with valid/ready handshakes and iterative mul/div.
// Optional macro ULA_STICKY_OV_EN adds ov_clr/ov_sticky.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ov,
  output logic             dz
`ifdef ULA_STICKY_OV_EN
  ,
  input  logic             ov_clr,
  output logic             ov_sticky
`endif
);

  ula_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_ov, r_dz, r_is_div;

  logic             w_accept, w_is_iter, w_done;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ov;
  logic [WIDTH-1:0] w_prod_lo, w_quot;
  logic             w_mul_ov, w_dz;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign ov        = r_ov;
  assign dz        = r_dz;
  assign w_accept  = in_valid & in_ready;
  assign w_is_iter = is_iter_op(op);
  assign w_sum     = {1'b0, a} + {1'b0, b};

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept & w_is_iter),
    .i_div     (op == OP_DIV),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_done),
    .o_prod_lo (w_prod_lo),
    .o_ov      (w_mul_ov),
    .o_quot    (w_quot),
    .o_dz      (w_dz)
  );

  always_comb begin
    w_alu_res = '0;
    w_alu_ov  = 1'b0;
    case (op)
      OP_ADD:   begin w_alu_res = w_sum[WIDTH-1:0]; w_alu_ov = w_sum[WIDTH]; end
      OP_SUB:   begin w_alu_res = a - b; w_alu_ov = (a < b); end
      OP_EQ:    w_alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_GT:    w_alu_res = {{(WIDTH-1){1'b0}}, a > b};
      OP_LT:    w_alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_NE:    w_alu_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_AND:   w_alu_res = a & b;
      OP_NAND:  w_alu_res = ~(a & b);
      OP_OR:    w_alu_res = a | b;
      OP_NOR:   w_alu_res = ~(a | b);
      OP_XOR:   w_alu_res = a ^ b;
      OP_XNOR:  w_alu_res = ~(a ^ b);
      OP_NOT_A: w_alu_res = ~a;
      OP_NOT_B: w_alu_res = ~b;
      default:  w_alu_res = '0;  // mul/div results come from the iterative engine
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_iter ? ST_EXEC : ST_DONE;
      ST_EXEC: if (w_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_ov     <= 1'b0;
      r_dz     <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_is_div <= (op == OP_DIV);
        if (!w_is_iter) begin
          r_result <= w_alu_res;
          r_ov     <= w_alu_ov;
          r_dz     <= 1'b0;
        end
      end else if (r_state == ST_EXEC && w_done) begin
        r_result <= r_is_div ? w_quot : w_prod_lo;
        r_ov     <= r_is_div ? 1'b0 : w_mul_ov;
        r_dz     <= r_is_div & w_dz;
      end
    end
  end

`ifdef ULA_STICKY_OV_EN
  logic r_ov_sticky;

  assign ov_sticky = r_ov_sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov_sticky <= 1'b0;
    end else if (out_valid && out_ready && (r_ov || r_dz)) begin
      r_ov_sticky <= 1'b1;
    end else if (ov_clr) begin
      r_ov_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Randomised self-checking bench for ula_seq against a plain-arithmetic reference model.
module tb_ula_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ov, dz;
`ifdef ULA_STICKY_OV_EN
  logic         ov_clr;
  logic         ov_sticky;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ov        (ov),
    .dz        (dz)
`ifdef ULA_STICKY_OV_EN
    ,
    .ov_clr    (ov_clr),
    .ov_sticky (ov_sticky)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Returns {dz, ov, result}.
  function automatic logic [W+1:0] model(input logic [3:0] o, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    longint unsigned x, y, m, r;
    logic v, z;
    x = av; y = bv; m = 64'd1 << W; r = 0; v = 1'b0; z = 1'b0;
    case (o)
      4'd0:  begin r = x + y; v = (r >= m); end
      4'd1:  begin r = x + m - y; v = (x < y); end
      4'd2:  begin r = x * y; v = (r >= m); end
      4'd3:  if (y == 0) begin r = m - 1; z = 1'b1; end else r = x / y;
      4'd4:  r = (x == y) ? 1 : 0;
      4'd5:  r = (x > y) ? 1 : 0;
      4'd6:  r = (x < y) ? 1 : 0;
      4'd7:  r = (x != y) ? 1 : 0;
      4'd8:  r = x & y;
      4'd9:  r = ~(x & y);
      4'd10: r = x | y;
      4'd11: r = ~(x | y);
      4'd12: r = x ^ y;
      4'd13: r = ~(x ^ y);
      4'd14: r = ~x;
      default: r = ~y;
    endcase
    return {z, v, W'(r % m)};
  endfunction

  // Issue one request, measure latency, apply `hold` cycles of backpressure, then handshake.
  task automatic do_op(input logic [3:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input int hold);
    logic [W+1:0] exp;
    int lat, exp_lat;
    exp     = model(op_v, a_v, b_v);
    exp_lat = (op_v == 4'd2 || op_v == 4'd3) ? W + 1 : 1;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = a_v; b = b_v; op = op_v;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", result, exp[W-1:0]);
    check("ov", ov, exp[W]);
    check("dz", dz, exp[W+1]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_out", {dz, ov, result, out_valid}, {exp, 1'b1});
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
`ifdef ULA_STICKY_OV_EN
    ov_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {ov, dz}, 0);

    do_op(4'd0, 8'd200, 8'd100, 0);
`ifdef ULA_STICKY_OV_EN
    check("sticky_set", ov_sticky, 1);
`endif
    do_op(4'd4, 8'd9, 8'd9, 0);
`ifdef ULA_STICKY_OV_EN
    check("sticky_hold", ov_sticky, 1);
    ov_clr = 1'b1;
    @(posedge clk); #1;
    ov_clr = 1'b0;
    check("sticky_clr", ov_sticky, 0);
`endif
    do_op(4'd1, 8'd5, 8'd7, 0);
    do_op(4'd2, 8'd16, 8'd16, 0);
    do_op(4'd2, 8'd15, 8'd17, 0);
    do_op(4'd3, 8'd100, 8'd7, 0);
    do_op(4'd3, 8'd100, 8'd0, 0);
    do_op(4'd3, 8'd0, 8'd0, 0);
    do_op(4'd2, 8'd255, 8'd255, 0);
    do_op(4'd0, 8'd17, 8'd3, 5);
    do_op(4'd3, 8'd255, 8'd1, 5);

    // Reset in the middle of a multiply drops the result.
    in_valid = 1'b1; a = 8'd16; b = 8'd16; op = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (W + 2) @(posedge clk);
    #1 check("abort_no_result", out_valid, 0);
    do_op(4'd2, 8'd12, 8'd11, 0);

    for (int t = 0; t < 200; t++) begin
      logic [3:0]   r_op;
      logic [W-1:0] ra, rb;
      r_op = 4'($urandom);
      ra   = W'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op(r_op, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
